// File: rtl/cla_pkg.sv
// Shared types and helpers for the nibble-serial carry look-ahead adder.
package cla_pkg;

    // Bits handled per clock by one look-ahead slice.
    localparam int NIB_W = 4;

    // Widest operand nibble_select can slice; operands are zero-extended to this width.
    localparam int MAX_W = 1024;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Returns nibble idx (0 = least significant) of a zero-extended operand.
    function automatic logic [NIB_W-1:0] nibble_select(input logic [MAX_W-1:0] operand,
                                                       input int unsigned      idx);
        return operand[idx*NIB_W +: NIB_W];
    endfunction

endpackage

// File: rtl/carry_generation.sv
// Single-bit generate term: this bit position creates a carry on its own.
module carry_generation (
    input  logic x,
    input  logic y,
    output logic g
);

    assign g = x & y;

endmodule

// File: rtl/cla_nibble.sv
// Combinational 4-bit carry look-ahead slice. Exports the carries into and out
// of the top bit (for overflow) plus group generate/propagate for a future
// second look-ahead level.
module cla_nibble
    import cla_pkg::*;
(
    input  logic [NIB_W-1:0] x,
    input  logic [NIB_W-1:0] y,
    input  logic             c0,
    output logic [NIB_W-1:0] s,
    output logic             c3,
    output logic             c4,
    output logic             grp_g,
    output logic             grp_p
);

    logic [NIB_W-1:0] g;
    logic [NIB_W-1:0] p;
    logic             c1;
    logic             c2;

    for (genvar i = 0; i < NIB_W; i++) begin : g_gen
        carry_generation u_gen (
            .x (x[i]),
            .y (y[i]),
            .g (g[i])
        );
    end

    assign p = x ^ y;

    // Every carry is a flat sum of products of g, p and c0: no ripple inside the slice.
    assign c1 = g[0] | (p[0] & c0);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);

    assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign grp_p = &p;
    assign c4    = grp_g | (grp_p & c0);

    assign s = p ^ {c3, c2, c1, c0};

endmodule

// File: rtl/cla_serial_adder.sv
// WIDTH-bit adder that walks the operands one nibble per clock through a
// carry look-ahead slice, chaining the nibble carry through a register.
// Valid/ready handshake on both sides; a waiting result can be replaced by
// new operands on the same edge it is consumed.
module cla_serial_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIBS  = WIDTH / NIB_W;
    localparam int IDX_W = (NIBS > 1) ? $clog2(NIBS) : 1;

    if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W || WIDTH > MAX_W) begin : g_bad_width
        $error("cla_serial_adder: WIDTH must be a multiple of 4 in the range 4..MAX_W");
    end

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   sum_r;
    logic               cout_r;
    logic               ovf_r;
    logic               accept;
    logic               last_nib;
    logic [NIB_W-1:0]   nib_x;
    logic [NIB_W-1:0]   nib_y;
    logic [NIB_W-1:0]   nib_s;
    logic               nib_c3;
    logic               nib_c4;
    logic               grp_g;
    logic               grp_p;
    logic               c4_lookahead;

    assign accept   = in_valid & in_ready;
    assign last_nib = (idx == IDX_W'(NIBS - 1));

    assign nib_x = nibble_select(MAX_W'(a_r), 32'(idx));
    assign nib_y = nibble_select(MAX_W'(b_r), 32'(idx));

    cla_nibble u_nibble (
        .x     (nib_x),
        .y     (nib_y),
        .c0    (carry),
        .s     (nib_s),
        .c3    (nib_c3),
        .c4    (nib_c4),
        .grp_g (grp_g),
        .grp_p (grp_p)
    );

    // Final carry taken through the group terms; equal to the slice's own c4.
    assign c4_lookahead = grp_g | (grp_p & carry);

    // State register.
    // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state and handshake outputs.
    // NOTE: every output gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                if (last_nib) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_next = in_valid ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, nibble stepping and result registers.
    // NOTE: operand/result registers are reset too, so outputs read as zero right after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= '0;
            b_r    <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (accept) begin
            a_r   <= a;
            b_r   <= b;
            carry <= cin;
            idx   <= '0;
        end else if (state == RUN) begin
            sum_r[idx*NIB_W +: NIB_W] <= nib_s;
            carry <= nib_c4;
            idx   <= idx + 1'b1;
            if (last_nib) begin
                cout_r <= c4_lookahead;
                ovf_r  <= nib_c3 ^ nib_c4;
            end
        end
    end

    assign sum  = sum_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_cla_serial_adder.sv
// Bench for cla_serial_adder: a 16-bit instance for the main tests and a
// 4-bit instance for the single-nibble case, checked against integer arithmetic.
module tb_cla_serial_adder;

    localparam int W    = 16;
    localparam int NIBS = W / 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;

    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    logic         in_valid4 = 1'b0;
    logic         in_ready4;
    logic [3:0]   a4 = '0;
    logic [3:0]   b4 = '0;
    logic         cin4 = 1'b0;
    logic         out_valid4;
    logic         out_ready4 = 1'b0;
    logic [3:0]   sum4;
    logic         cout4;
    logic         ovf4;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs[6];

    cla_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    cla_serial_adder #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a4),
        .b         (b4),
        .cin       (cin4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .sum       (sum4),
        .cout      (cout4),
        .ovf       (ovf4)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer addition; returns {ovf, cout, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        logic [W:0] t;
        logic       o;
        t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        o = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
        return {o, t};
    endfunction

    task automatic check_vals(input string name, input logic [W-1:0] es, input logic ec,
                              input logic eo);
        check({name, " sum"},  32'(sum),  32'(es));
        check({name, " cout"}, 32'(cout), 32'(ec));
        check({name, " ovf"},  32'(ovf),  32'(eo));
    endtask

    task automatic check_model(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic c);
        logic [W+1:0] r;
        r = model(x, y, c);
        check_vals(name, r[W-1:0], r[W], r[W+1]);
    endtask

    // Counts edges from the current sample point until out_valid rises (bounded).
    task automatic wait_result(input string name, input int exp_lat);
        int cnt;
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        check({name, " latency"}, 32'(cnt), 32'(exp_lat));
    endtask

    // Presents operands from IDLE, scrambles the inputs after acceptance, waits for the result.
    task automatic do_add(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = x; b = y; cin = c;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a   = W'($urandom);
        b   = W'($urandom);
        cin = 1'($urandom);
        wait_result(name, NIBS);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         c;
        logic [W-1:0] ops_a[5];
        logic [W-1:0] ops_b[5];
        logic         ops_c[5];
        logic [4:0]   t4;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};

        // Reset values.
        #1;
        check("reset in_ready",   32'(in_ready),   32'd1);
        check("reset out_valid",  32'(out_valid),  32'd0);
        check_vals("reset", '0, 1'b0, 1'b0);
        check("reset4 in_ready",  32'(in_ready4),  32'd1);
        check("reset4 out_valid", 32'(out_valid4), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors.
        for (int i = 0; i < 6; i++) begin
            do_add($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin);
            check_vals($sformatf("vec%0d", i), vecs[i].sum, vecs[i].cout, vecs[i].ovf);
            release_result();
            check($sformatf("vec%0d idle in_ready", i), 32'(in_ready), 32'd1);
        end

        // Random operands against the model.
        for (int i = 0; i < 30; i++) begin
            x = W'($urandom);
            y = W'($urandom);
            c = 1'($urandom);
            do_add($sformatf("rnd%0d", i), x, y, c);
            check_model($sformatf("rnd%0d", i), x, y, c);
            release_result();
        end

        // Backpressure: result held while the sink stalls, then replaced on release.
        do_add("bp", 16'h1234, 16'h4321, 1'b1);
        in_valid = 1'b1;
        a = 16'hAAAA; b = 16'h5555; cin = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("bp%0d out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d in_ready", i),  32'(in_ready),  32'd0);
            check_vals($sformatf("bp%0d", i), 16'h5556, 1'b0, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        check("bp accepted out_valid", 32'(out_valid), 32'd0);
        check("bp accepted in_ready",  32'(in_ready),  32'd0);
        wait_result("bp next", NIBS);
        check_model("bp next", 16'hAAAA, 16'h5555, 1'b1);
        release_result();

        // Back-to-back: in_valid and out_ready held high, one result every NIBS+1 cycles.
        for (int i = 0; i < 5; i++) begin
            ops_a[i] = W'($urandom);
            ops_b[i] = W'($urandom);
            ops_c[i] = 1'($urandom);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = ops_a[0]; b = ops_b[0]; cin = ops_c[0];
        @(posedge clk); #1;
        a = ops_a[1]; b = ops_b[1]; cin = ops_c[1];
        for (int r = 0; r < 4; r++) begin
            wait_result($sformatf("b2b%0d", r), NIBS);
            check_model($sformatf("b2b%0d", r), ops_a[r], ops_b[r], ops_c[r]);
            check($sformatf("b2b%0d in_ready", r), 32'(in_ready), 32'd1);
            if (r == 3) in_valid = 1'b0;
            @(posedge clk); #1;
            check($sformatf("b2b%0d gone", r), 32'(out_valid), 32'd0);
            if (r < 3) begin
                check($sformatf("b2b%0d no idle", r), 32'(in_ready), 32'd0);
                a = ops_a[r+2]; b = ops_b[r+2]; cin = ops_c[r+2];
            end else begin
                check("b2b end idle", 32'(in_ready), 32'd1);
            end
        end
        out_ready = 1'b0;

        // Reset during the second RUN cycle.
        in_valid = 1'b1;
        a = 16'h1111; b = 16'h2222; cin = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst in_ready",  32'(in_ready),  32'd1);
        check_vals("midrst", '0, 1'b0, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        do_add("after rst", 16'hF00D, 16'h0FF3, 1'b1);
        check_model("after rst", 16'hF00D, 16'h0FF3, 1'b1);
        release_result();

        // WIDTH=4 instance: single RUN cycle.
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin
                a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
            end else begin
                a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
            end
            t4 = {1'b0, a4} + {1'b0, b4} + {4'b0, cin4};
            in_valid4 = 1'b1;
            @(posedge clk); #1;
            in_valid4 = 1'b0;
            check($sformatf("w4_%0d mid out_valid", i), 32'(out_valid4), 32'd0);
            @(posedge clk); #1;
            check($sformatf("w4_%0d out_valid", i), 32'(out_valid4), 32'd1);
            check($sformatf("w4_%0d sum", i),  32'(sum4),  32'(t4[3:0]));
            check($sformatf("w4_%0d cout", i), 32'(cout4), 32'(t4[4]));
            check($sformatf("w4_%0d ovf", i),  32'(ovf4),
                  32'((a4[3] == b4[3]) && (t4[3] != a4[3])));
            out_ready4 = 1'b1;
            @(posedge clk); #1;
            out_ready4 = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cla_serial_adder.md
Name: cla_serial_adder

Overview:
- Multi-cycle wide adder that processes one 4-bit nibble per clock through a carry look-ahead slice.
- It is the consumer of the per-bit generate (g = X&Y) and propagate terms, and chains the nibble carry-out through a register.
- Adds two WIDTH-bit operands with a valid/ready handshake on input and output.
- Sits between operand source logic and any result sink in the arithmetic datapath.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and ≥4 (checked at elaboration).
- NIBS, WIDTH/4, derived localparam: number of nibble cycles.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry into bit 0
- out_valid  output  1  result valid
- out_ready  input  1  sink accepts result
- sum  output  WIDTH  a+b+cin modulo 2^WIDTH
- cout  output  1  carry out of bit WIDTH-1
- ovf  output  1  signed overflow, computed as carry into MSB XOR carry out of MSB

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready=1; out_valid=0; sum=0; cout=0; ovf=0.
  - Nibble index, carry register and operand registers cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at a rising edge: latch a, b and cin into the carry register, set idx=0, go to RUN.
- RUN:
  - in_ready=0; out_valid=0.
  - Each cycle, nibble idx of the latched operands feeds the CLA slice:
    - g[i]=a&b, p[i]=a^b
    - c1=g0|p0c0
    - c2=g1|p1g0|p1p0c0
    - c3 and c4 follow the same pattern
    - s[i]=p[i]^c[i]
  - At the edge: write nibble idx of sum, load c4 into the carry register, increment idx.
  - When idx==NIBS-1: also capture cout=c4 and ovf=c3^c4 from the MSB nibble, then go to DONE.
- DONE:
  - out_valid=1; sum, cout and ovf held stable while out_valid=1 and out_ready=0.
  - in_ready = out_ready.
  - out_ready=1 and in_valid=0: go to IDLE.
  - out_ready=1 and in_valid=1: accept the new operands in the same edge and go to RUN (back-to-back, no bubble).
- Latency:
  - Acceptance edge E0; out_valid rises after edge E_NIBS, i.e. NIBS cycles.
  - Throughput is one result per NIBS+1 cycles when the sink never stalls.
- Width rules: all arithmetic is modulo 2^WIDTH; cout is the true carry; ovf is only meaningful for two's-complement interpretation.
- Input stability: a, b and cin are sampled only at the acceptance edge; later changes are ignored.
- in_valid while busy: in_valid during RUN is not accepted. The source must hold it, per valid/ready rules.
- Reset mid-operation: in-flight result discarded, all outputs return to reset values immediately.
- Boundary case: WIDTH=4 gives NIBS=1, so there is one RUN cycle and DONE follows directly.
- Partial sum: the sum register is partially updated during RUN and is only defined while out_valid=1.

Decomposition:
- Package cla_pkg:
  - NIB_W=4
  - state enum {IDLE, RUN, DONE}
  - function nibble_select(operand, idx)
- Sub-module cla_nibble (combinational):
  - Inputs: x[3:0], y[3:0], c0.
  - Outputs: s[3:0], c3, c4, plus group G and P.
  - Builds generate terms from four carry_generation instances and propagate with XOR.
  - Group G/P exported for future two-level look-ahead.
- The top level holds the FSM, idx counter, carry register and output registers.

Test Plan:
- WIDTH=16, a=0xFFFF, b=0x0001, cin=0 → after 4 cycles out_valid=1, sum=0x0000, cout=1, ovf=0.
- a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, ovf=1; a=0x1234, b=0x4321, cin=1 → sum=0x5556, cout=0, ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → sum, cout and ovf stable, in_ready=0; release → accepted in the out_ready=1 cycle.
- Back-to-back: in_valid held high, out_ready=1 → second operands accepted on the edge the first result leaves; results arrive every 5 cycles with no IDLE visit.
- Reset mid-op: assert rst_n=0 during the 2nd RUN cycle → out_valid=0, sum=0, in_ready=1 immediately; a fresh add afterwards gives the correct result.
- WIDTH=4 build: a=0xF, b=0xF, cin=1 → 1 cycle latency, sum=0xF, cout=1, ovf=0.
